uart_seq: RTL and testbench

UART_SEQ -- requirements
Module: uart_seq

---
 rtl/uart_seq.sv | 150 +++++++++++++++
 tb/tb_uart_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_seq.sv
// uart_seq: register front-end and transmit launch sequencer for a UART.
// Bridges a 4-register bus interface to external TX/RX FIFOs (FWFT) and
// hands characters one at a time to an external transmitter.
//
// TX FSM states
//   state      | meaning
//   IDLE       | no character in flight, baud select may follow CTRL
//   LAUNCH     | one-cycle start pulse to transmitter and pop of TX FIFO
//   WAIT_START | waiting for the transmitter to report busy
//   WAIT_DONE  | waiting for the transmitter to finish the character
module uart_seq #(
  parameter int DataWidth    = 8,
  parameter int BaudSelWidth = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic                    rd_en_i,
  input  logic [1:0]              addr_i,
  input  logic [15:0]             data_i,
  output logic [15:0]             data_o,
  output logic                    txf_wr_en_o,
  output logic [DataWidth-1:0]    txf_wr_data_o,
  input  logic                    txf_full_i,
  output logic                    txf_rd_en_o,
  input  logic                    txf_empty_i,
  input  logic [DataWidth-1:0]    txf_rd_data_i,
  output logic                    tx_dv_o,
  output logic [DataWidth-1:0]    tx_data_o,
  input  logic                    tx_busy_i,
  input  logic                    rx_dv_i,
  input  logic [DataWidth-1:0]    rx_data_i,
  output logic                    rxf_wr_en_o,
  output logic [DataWidth-1:0]    rxf_wr_data_o,
  input  logic                    rxf_full_i,
  output logic                    rxf_rd_en_o,
  input  logic                    rxf_empty_i,
  input  logic [DataWidth-1:0]    rxf_rd_data_i,
  output logic [BaudSelWidth-1:0] baud_sel_o,
  output logic                    irq_o
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} tx_state_t;

  localparam logic [5:0] CtrlReset = 6'h0C;

  tx_state_t   state;
  logic [5:0]  ctrl;
  logic        rx_overrun;
  logic        tx_drop;

  logic        tx_en, rx_en, irq_rx_en, irq_txe_en;
  logic        wr_tx, wr_status, wr_ctrl, rd_rx, rx_take;
  logic        tx_active, tx_start;
  logic        overrun_next, drop_next;
  logic [15:0] status;
  logic [15:0] rd_data;
  logic        unused_bits;

  assign tx_en      = ctrl[2];
  assign rx_en      = ctrl[3];
  assign irq_rx_en  = ctrl[4];
  assign irq_txe_en = ctrl[5];

  // Bus strobes are masked during reset so nothing leaks to the FIFOs.
  assign wr_tx     = !rst_i && wr_en_i && (addr_i == 2'd0);
  assign wr_status = !rst_i && wr_en_i && (addr_i == 2'd2);
  assign wr_ctrl   = !rst_i && wr_en_i && (addr_i == 2'd3);
  assign rd_rx     = !rst_i && rd_en_i && (addr_i == 2'd1);
  assign rx_take   = !rst_i && rx_dv_i && rx_en;

  assign txf_wr_en_o   = wr_tx && !txf_full_i;
  assign txf_wr_data_o = data_i[DataWidth-1:0];
  assign rxf_rd_en_o   = rd_rx && !rxf_empty_i;
  assign rxf_wr_en_o   = rx_take && !rxf_full_i;
  assign rxf_wr_data_o = rx_data_i;

  assign tx_active = (state != IDLE);
  assign tx_start  = (state == IDLE) && tx_en && !txf_empty_i && !tx_busy_i;

  // A set event in the same cycle as a W1C clear keeps the flag set.
  assign overrun_next = (rx_take && rxf_full_i) || (rx_overrun && !(wr_status && data_i[5]));
  assign drop_next    = (wr_tx && txf_full_i)   || (tx_drop && !(wr_status && data_i[6]));

  assign status = {9'd0, tx_drop, rx_overrun, tx_active,
                   rxf_empty_i, rxf_full_i, txf_empty_i, txf_full_i};

  // Upper write-data bits are don't-care for every register.
  assign unused_bits = ^data_i;

  // Read-data select for the registered read port.
  always_comb begin
    rd_data = 16'd0;
    case (addr_i)
      2'd1:    rd_data = rxf_empty_i ? 16'd0 : 16'(rxf_rd_data_i);
      2'd2:    rd_data = status;
      2'd3:    rd_data = {10'd0, ctrl};
      default: rd_data = 16'd0;
    endcase
  end

  // Register file: CTRL, sticky flags, read data and interrupt.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl       <= CtrlReset;
      rx_overrun <= 1'b0;
      tx_drop    <= 1'b0;
      data_o     <= 16'd0;
      irq_o      <= 1'b0;
    end else begin
      rx_overrun <= overrun_next;
      tx_drop    <= drop_next;
      if (wr_ctrl) ctrl <= data_i[5:0];
      if (rd_en_i) data_o <= rd_data;
      irq_o <= (irq_rx_en && !rxf_empty_i) ||
               (irq_txe_en && txf_empty_i && !tx_active) ||
               overrun_next;
    end
  end

  // TX launch FSM; baud select only follows CTRL while no character is in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      tx_dv_o     <= 1'b0;
      txf_rd_en_o <= 1'b0;
      tx_data_o   <= '0;
      baud_sel_o  <= '0;
    end else begin
      tx_dv_o     <= 1'b0;
      txf_rd_en_o <= 1'b0;
      if ((state == IDLE) && !tx_start) baud_sel_o <= BaudSelWidth'(ctrl[1:0]);
      case (state)
        IDLE: begin
          if (tx_start) begin
            state       <= LAUNCH;
            tx_dv_o     <= 1'b1;
            txf_rd_en_o <= 1'b1;
            tx_data_o   <= txf_rd_data_i;
          end
        end
        LAUNCH:     state <= WAIT_START;
        WAIT_START: if (tx_busy_i) state <= WAIT_DONE;
        WAIT_DONE:  if (!tx_busy_i) state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_seq.sv
// Testbench for uart_seq: directed scenarios with literal expectations,
// then randomized traffic, all outputs compared every cycle to a reference model.
module tb_uart_seq;

  logic        clk;
  logic        rst;
  logic        wr_en, rd_en;
  logic [1:0]  addr;
  logic [15:0] wdata, rdata;
  logic        txf_wr_en;
  logic [7:0]  txf_wr_data;
  logic        txf_full, txf_rd_en, txf_empty;
  logic [7:0]  txf_head;
  logic        tx_dv;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        rx_dv;
  logic [7:0]  rx_data;
  logic        rxf_wr_en;
  logic [7:0]  rxf_wr_data;
  logic        rxf_full, rxf_rd_en, rxf_empty;
  logic [7:0]  rxf_head;
  logic [1:0]  baud_sel;
  logic        irq;

  int n_err    = 0;
  int n_checks = 0;
  bit checking = 1'b0;

  // reference model: values the registered outputs must hold this cycle
  logic [15:0] m_data;
  logic [7:0]  m_tx_data;
  logic        m_launch;
  logic        m_in_frame;
  logic        m_busy_seen;
  logic [1:0]  m_baud;
  logic        m_irq;
  logic [5:0]  m_ctrl;
  logic        m_ovr, m_drop;

  uart_seq #(.DataWidth(8), .BaudSelWidth(2)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .rd_en_i(rd_en), .addr_i(addr),
    .data_i(wdata), .data_o(rdata),
    .txf_wr_en_o(txf_wr_en), .txf_wr_data_o(txf_wr_data), .txf_full_i(txf_full),
    .txf_rd_en_o(txf_rd_en), .txf_empty_i(txf_empty), .txf_rd_data_i(txf_head),
    .tx_dv_o(tx_dv), .tx_data_o(tx_data), .tx_busy_i(tx_busy),
    .rx_dv_i(rx_dv), .rx_data_i(rx_data),
    .rxf_wr_en_o(rxf_wr_en), .rxf_wr_data_o(rxf_wr_data), .rxf_full_i(rxf_full),
    .rxf_rd_en_o(rxf_rd_en), .rxf_empty_i(rxf_empty), .rxf_rd_data_i(rxf_head),
    .baud_sel_o(baud_sel), .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data      = 16'd0;
    m_tx_data   = 8'd0;
    m_launch    = 1'b0;
    m_in_frame  = 1'b0;
    m_busy_seen = 1'b0;
    m_baud      = 2'd0;
    m_irq       = 1'b0;
    m_ctrl      = 6'h0C;
    m_ovr       = 1'b0;
    m_drop      = 1'b0;
  endtask

  // Compare process: every cycle, check outputs then advance the model.
  initial begin : compare
    logic e_txpush, e_rxpush, e_rxpop, go, ovr_n, drop_n;
    model_reset();
    wait (checking);
    forever begin
      #2;
      e_txpush = !rst && wr_en && (addr == 2'd0) && !txf_full;
      e_rxpush = !rst && rx_dv && m_ctrl[3] && !rxf_full;
      e_rxpop  = !rst && rd_en && (addr == 2'd1) && !rxf_empty;
      chk("cmp_txf_wr_en", 16'(txf_wr_en), 16'(e_txpush));
      if (e_txpush) chk("cmp_txf_wr_data", 16'(txf_wr_data), {8'd0, wdata[7:0]});
      chk("cmp_rxf_wr_en", 16'(rxf_wr_en), 16'(e_rxpush));
      if (e_rxpush) chk("cmp_rxf_wr_data", 16'(rxf_wr_data), {8'd0, rx_data});
      chk("cmp_rxf_rd_en", 16'(rxf_rd_en), 16'(e_rxpop));
      chk("cmp_data_o",    rdata, m_data);
      chk("cmp_tx_dv",     16'(tx_dv), 16'(m_launch));
      chk("cmp_txf_rd_en", 16'(txf_rd_en), 16'(m_launch));
      chk("cmp_tx_data",   16'(tx_data), {8'd0, m_tx_data});
      chk("cmp_baud_sel",  16'(baud_sel), 16'(m_baud));
      chk("cmp_irq",       16'(irq), 16'(m_irq));

      if (rst) begin
        model_reset();
      end else begin
        go     = !m_in_frame && m_ctrl[2] && !txf_empty && !tx_busy;
        ovr_n  = (rx_dv && m_ctrl[3] && rxf_full) ||
                 (m_ovr && !(wr_en && (addr == 2'd2) && wdata[5]));
        drop_n = (wr_en && (addr == 2'd0) && txf_full) ||
                 (m_drop && !(wr_en && (addr == 2'd2) && wdata[6]));
        if (rd_en) begin
          case (addr)
            2'd0:    m_data = 16'd0;
            2'd1:    m_data = rxf_empty ? 16'd0 : {8'd0, rxf_head};
            2'd2:    m_data = {9'd0, m_drop, m_ovr, m_in_frame,
                               rxf_empty, rxf_full, txf_empty, txf_full};
            default: m_data = {10'd0, m_ctrl};
          endcase
        end
        m_irq = (m_ctrl[4] && !rxf_empty) || (m_ctrl[5] && txf_empty && !m_in_frame) || ovr_n;
        if (!m_in_frame && !go) m_baud = m_ctrl[1:0];
        if (go) begin
          m_in_frame  = 1'b1;
          m_busy_seen = 1'b0;
          m_launch    = 1'b1;
          m_tx_data   = txf_head;
        end else if (m_launch) begin
          m_launch = 1'b0;
        end else if (m_in_frame && !m_busy_seen) begin
          m_busy_seen = tx_busy;
        end else if (m_in_frame && !tx_busy) begin
          m_in_frame = 1'b0;
        end
        m_ovr  = ovr_n;
        m_drop = drop_n;
        if (wr_en && (addr == 2'd3)) m_ctrl = wdata[5:0];
      end
      @(negedge clk);
    end
  end

  task automatic idle_bus();
    wr_en = 1'b0; rd_en = 1'b0; addr = 2'd0; wdata = 16'd0; rx_dv = 1'b0;
  endtask

  initial begin : stim
    rst = 1'b1; idle_bus();
    txf_full = 1'b0; txf_empty = 1'b1; txf_head = 8'd0; tx_busy = 1'b0;
    rx_data = 8'd0; rxf_full = 1'b0; rxf_empty = 1'b1; rxf_head = 8'd0;
    // strobes during reset must be ignored
    wr_en = 1'b1; wdata = 16'h0055; rx_dv = 1'b1; rx_data = 8'h11;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    #1;
    chk("rst_txf_wr_en", 16'(txf_wr_en), 16'd0);
    chk("rst_rxf_wr_en", 16'(rxf_wr_en), 16'd0);
    chk("rst_data_o", rdata, 16'd0);
    chk("rst_tx_dv", 16'(tx_dv), 16'd0);
    chk("rst_baud", 16'(baud_sel), 16'd0);
    chk("rst_irq", 16'(irq), 16'd0);
    @(negedge clk); rst = 1'b0; idle_bus();

    // TXDATA 0x41 push and launch
    @(negedge clk); wr_en = 1'b1; addr = 2'd0; wdata = 16'h0041; txf_empty = 1'b0; txf_head = 8'h41;
    #1;
    chk("tx_push_en", 16'(txf_wr_en), 16'd1);
    chk("tx_push_data", 16'(txf_wr_data), 16'h0041);
    @(negedge clk); wr_en = 1'b0; txf_empty = 1'b1;
    chk("launch_dv", 16'(tx_dv), 16'd1);
    chk("launch_data", 16'(tx_data), 16'h0041);
    chk("launch_pop", 16'(txf_rd_en), 16'd1);
    @(negedge clk);
    chk("launch_one_cycle", 16'(tx_dv), 16'd0);
    tx_busy = 1'b1; rd_en = 1'b1; addr = 2'd2;
    @(negedge clk); rd_en = 1'b0;
    chk("status_active", rdata, 16'h001A);
    wr_en = 1'b1; addr = 2'd3; wdata = 16'h000E;
    @(negedge clk); wr_en = 1'b0;
    chk("baud_hold_1", 16'(baud_sel), 16'd0);
    @(negedge clk); tx_busy = 1'b0;
    chk("baud_hold_2", 16'(baud_sel), 16'd0);
    @(negedge clk); rd_en = 1'b1; addr = 2'd3;
    chk("baud_hold_3", 16'(baud_sel), 16'd0);
    @(negedge clk); rd_en = 1'b0;
    chk("baud_loaded", 16'(baud_sel), 16'd2);
    chk("ctrl_read", rdata, 16'h000E);

    // TXDATA write while full -> tx_drop, then W1C
    @(negedge clk); wr_en = 1'b1; addr = 2'd0; wdata = 16'h0077; txf_full = 1'b1;
    #1 chk("full_no_push", 16'(txf_wr_en), 16'd0);
    @(negedge clk); wr_en = 1'b0; txf_full = 1'b0; rd_en = 1'b1; addr = 2'd2;
    @(negedge clk); rd_en = 1'b0;
    chk("status_drop", rdata, 16'h004A);
    wr_en = 1'b1; addr = 2'd2; wdata = 16'h0040;
    @(negedge clk); wr_en = 1'b0; rd_en = 1'b1; addr = 2'd2;
    @(negedge clk); rd_en = 1'b0;
    chk("status_drop_clr", rdata, 16'h000A);

    // RX push 0x5A and RXDATA read
    @(negedge clk); rx_dv = 1'b1; rx_data = 8'h5A;
    #1;
    chk("rx_push_en", 16'(rxf_wr_en), 16'd1);
    chk("rx_push_data", 16'(rxf_wr_data), 16'h005A);
    @(negedge clk); rx_dv = 1'b0; rxf_empty = 1'b0; rxf_head = 8'h5A; rd_en = 1'b1; addr = 2'd1;
    #1 chk("rx_pop", 16'(rxf_rd_en), 16'd1);
    @(negedge clk); rd_en = 1'b0; rxf_empty = 1'b1;
    chk("rx_read", rdata, 16'h005A);
    #1 chk("rx_pop_once", 16'(rxf_rd_en), 16'd0);
    @(negedge clk); rd_en = 1'b1; addr = 2'd1;
    #1 chk("rx_empty_no_pop", 16'(rxf_rd_en), 16'd0);
    @(negedge clk); addr = 2'd3;
    chk("rx_empty_read", rdata, 16'h0000);
    @(negedge clk); rd_en = 1'b0;
    chk("ctrl_read2", rdata, 16'h000E);
    @(negedge clk);
    chk("data_hold", rdata, 16'h000E);
    rd_en = 1'b1; addr = 2'd0;
    @(negedge clk); rd_en = 1'b0;
    chk("txdata_read_zero", rdata, 16'h0000);

    // overrun with simultaneous pop
    @(negedge clk); rx_dv = 1'b1; rx_data = 8'hC3; rxf_full = 1'b1; rxf_empty = 1'b0;
    rxf_head = 8'h33; rd_en = 1'b1; addr = 2'd1;
    #1;
    chk("ovr_no_push", 16'(rxf_wr_en), 16'd0);
    chk("ovr_pop", 16'(rxf_rd_en), 16'd1);
    @(negedge clk); rx_dv = 1'b0; rd_en = 1'b0; rxf_full = 1'b0; rxf_empty = 1'b1;
    chk("ovr_irq", 16'(irq), 16'd1);
    chk("ovr_read", rdata, 16'h0033);
    wr_en = 1'b1; addr = 2'd2; wdata = 16'h0020;
    @(negedge clk); wr_en = 1'b0;
    chk("ovr_clr_irq", 16'(irq), 16'd0);
    // set wins over same-cycle clear
    rx_dv = 1'b1; rxf_full = 1'b1; wr_en = 1'b1; addr = 2'd2; wdata = 16'h0060;
    @(negedge clk); rx_dv = 1'b0; rxf_full = 1'b0; wr_en = 1'b0; rd_en = 1'b1; addr = 2'd2;
    chk("set_wins_irq", 16'(irq), 16'd1);
    @(negedge clk); rd_en = 1'b0;
    chk("set_wins_status", rdata, 16'h002A);
    wr_en = 1'b1; addr = 2'd2; wdata = 16'h0020;
    @(negedge clk); wr_en = 1'b0;

    // tx_en cleared mid-frame, then reset in WAIT_DONE
    txf_empty = 1'b0; txf_head = 8'h99;
    @(negedge clk); txf_empty = 1'b1;
    chk("frame2_dv", 16'(tx_dv), 16'd1);
    chk("frame2_data", 16'(tx_data), 16'h0099);
    @(negedge clk); tx_busy = 1'b1;
    @(negedge clk); wr_en = 1'b1; addr = 2'd3; wdata = 16'h000A; txf_empty = 1'b0; txf_head = 8'hA5;
    @(negedge clk); wr_en = 1'b0;
    @(negedge clk); tx_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("tx_en_off_no_launch", 16'(tx_dv), 16'd0);
    end
    wr_en = 1'b1; addr = 2'd3; wdata = 16'h000E;
    @(negedge clk); wr_en = 1'b0;
    @(negedge clk);
    chk("reenable_dv", 16'(tx_dv), 16'd1);
    chk("reenable_data", 16'(tx_data), 16'h00A5);
    tx_busy = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_no_dv", 16'(tx_dv), 16'd0);
    end
    rst = 1'b0; rd_en = 1'b1; addr = 2'd2;
    @(negedge clk); addr = 2'd3;
    chk("rst_status_idle", rdata, 16'h0008);
    @(negedge clk); rd_en = 1'b0; txf_empty = 1'b1; tx_busy = 1'b0;
    chk("rst_ctrl", rdata, 16'h000C);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 199) == 0);
      wr_en = ($urandom_range(0, 3) == 0);
      rd_en = ($urandom_range(0, 2) == 0);
      addr  = 2'($urandom_range(0, 3));
      wdata = 16'($urandom);
      if (wr_en && (addr == 2'd3) && ($urandom_range(0, 3) != 0)) begin
        wdata[2] = 1'b1;
        wdata[3] = 1'b1;
      end
      txf_full  = ($urandom_range(0, 4) == 0);
      txf_empty = ($urandom_range(0, 2) == 0);
      txf_head  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) tx_busy = !tx_busy;
      rx_dv     = ($urandom_range(0, 3) == 0);
      rx_data   = 8'($urandom);
      rxf_full  = ($urandom_range(0, 4) == 0);
      rxf_empty = ($urandom_range(0, 2) == 0);
      rxf_head  = 8'($urandom);
    end
    @(negedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
